// File: rtl/ex_stage_hs_reg_if.sv
// Valid/ready handshake bundle between ID and the EX stage register.
// master is the surrounding pipeline (drives input side, consumes output side).
interface ex_stage_hs_reg_if #(
  parameter int unsigned PAYLOAD_W = 256
);
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_payload;

  modport master (
    output in_valid, in_payload, out_ready,
    input  in_ready, out_valid, out_payload
  );

  modport slave (
    input  in_valid, in_payload, out_ready,
    output in_ready, out_valid, out_payload
  );
endinterface

// File: rtl/ex_stage_hs_reg.sv
// ID->EX pipeline register with valid/ready handshake, synchronous flush,
// optional two-entry skid buffer and a saturating stall counter.
module ex_stage_hs_reg #(
  parameter int unsigned PAYLOAD_W = 256,
  parameter bit          SKID      = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ex_stage_hs_reg_if.slave      hs,
  input  logic                  flush,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt,
  input  logic                  stall_cnt_clr
);

  logic                 m_valid;
  logic [PAYLOAD_W-1:0] m_data;
  logic                 s_valid;
  logic                 accept;
  logic                 emit;

  assign accept = hs.in_valid & hs.in_ready;
  assign emit   = m_valid & hs.out_ready;

  assign hs.out_valid   = m_valid;
  assign hs.out_payload = m_data;
  assign occupancy      = {1'b0, m_valid} + {1'b0, s_valid};

  if (SKID) begin : g_skid
    logic [PAYLOAD_W-1:0] s_data;

    // in_ready depends only on the skid flop, breaking the out_ready->in_ready path
    assign hs.in_ready = ~s_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m_valid <= 1'b0;
        s_valid <= 1'b0;
        m_data  <= '0;
        s_data  <= '0;
      end else if (flush) begin
        m_valid <= 1'b0;
        s_valid <= 1'b0;
      end else if (emit && s_valid) begin
        m_data  <= s_data;
        s_valid <= 1'b0;
      end else if (accept && (!m_valid || emit)) begin
        m_data  <= hs.in_payload;
        m_valid <= 1'b1;
      end else if (accept) begin
        s_data  <= hs.in_payload;
        s_valid <= 1'b1;
      end else if (emit) begin
        m_valid <= 1'b0;
      end
    end
  end else begin : g_single
    assign s_valid     = 1'b0;
    assign hs.in_ready = ~m_valid | hs.out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m_valid <= 1'b0;
        m_data  <= '0;
      end else if (flush) begin
        m_valid <= 1'b0;
      end else if (accept) begin
        m_data  <= hs.in_payload;
        m_valid <= 1'b1;
      end else if (emit) begin
        m_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (m_valid && !hs.out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_stage_hs_reg.sv
// Directed bench for ex_stage_hs_reg: skid mode, single-entry mode and a
// narrow saturating counter instance, driven from one linear sequence.
module tb_ex_stage_hs_reg;

  localparam int unsigned PW = 32;

  logic clk;
  logic rst;
  logic flush_a, flush_b, flush_c;
  logic clr_a, clr_b, clr_c;
  logic [1:0]  occ_a, occ_b, occ_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int n_total;
  int n_pass;

  ex_stage_hs_reg_if #(.PAYLOAD_W(PW)) hs_a ();
  ex_stage_hs_reg_if #(.PAYLOAD_W(PW)) hs_b ();
  ex_stage_hs_reg_if #(.PAYLOAD_W(PW)) hs_c ();

  ex_stage_hs_reg #(.PAYLOAD_W(PW), .SKID(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .hs(hs_a), .flush(flush_a),
    .occupancy(occ_a), .stall_cnt(cnt_a), .stall_cnt_clr(clr_a)
  );

  ex_stage_hs_reg #(.PAYLOAD_W(PW), .SKID(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .hs(hs_b), .flush(flush_b),
    .occupancy(occ_b), .stall_cnt(cnt_b), .stall_cnt_clr(clr_b)
  );

  ex_stage_hs_reg #(.PAYLOAD_W(PW), .SKID(1'b1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .hs(hs_c), .flush(flush_c),
    .occupancy(occ_c), .stall_cnt(cnt_c), .stall_cnt_clr(clr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
    clr_a = 1'b0;   clr_b = 1'b0;   clr_c = 1'b0;
    hs_a.in_valid = 1'b0; hs_a.in_payload = '0; hs_a.out_ready = 1'b0;
    hs_b.in_valid = 1'b0; hs_b.in_payload = '0; hs_b.out_ready = 1'b0;
    hs_c.in_valid = 1'b0; hs_c.in_payload = '0; hs_c.out_ready = 1'b0;
    repeat (2) tick();

    // reset state
    chk("rst_a_out_valid", {31'b0, hs_a.out_valid}, 32'd0);
    chk("rst_a_occ", {30'b0, occ_a}, 32'd0);
    chk("rst_a_cnt", {16'b0, cnt_a}, 32'd0);
    chk("rst_a_payload", hs_a.out_payload, 32'd0);
    chk("rst_a_in_ready", {31'b0, hs_a.in_ready}, 32'd1);
    chk("rst_b_in_ready", {31'b0, hs_b.in_ready}, 32'd1);
    chk("rst_b_out_valid", {31'b0, hs_b.out_valid}, 32'd0);
    rst = 1'b0;
    tick();

    // stream 1..8 through the skid instance
    hs_a.in_valid  = 1'b1;
    hs_a.out_ready = 1'b1;
    for (int unsigned i = 1; i <= 8; i++) begin
      hs_a.in_payload = i;
      tick();
      chk("stream_payload", hs_a.out_payload, i);
      chk("stream_valid", {31'b0, hs_a.out_valid}, 32'd1);
      chk("stream_occ", {30'b0, occ_a}, 32'd1);
    end
    hs_a.in_valid = 1'b0;
    tick();
    chk("stream_drain", {31'b0, hs_a.out_valid}, 32'd0);

    // back-pressure: out_ready low for three edges
    hs_a.in_valid   = 1'b1;
    hs_a.in_payload = 32'hA0;
    tick();
    chk("bp_first", hs_a.out_payload, 32'hA0);
    hs_a.out_ready  = 1'b0;
    hs_a.in_payload = 32'hA1;
    tick();
    chk("bp_occ2", {30'b0, occ_a}, 32'd2);
    chk("bp_in_ready0", {31'b0, hs_a.in_ready}, 32'd0);
    hs_a.in_payload = 32'hA2;
    tick();
    tick();
    chk("bp_hold", hs_a.out_payload, 32'hA0);
    chk("bp_stall_cnt", {16'b0, cnt_a}, 32'd3);
    chk("bp_occ_hold", {30'b0, occ_a}, 32'd2);
    hs_a.out_ready = 1'b1;
    tick();
    chk("bp_second", hs_a.out_payload, 32'hA1);
    chk("bp_occ1", {30'b0, occ_a}, 32'd1);
    chk("bp_in_ready1", {31'b0, hs_a.in_ready}, 32'd1);
    tick();
    chk("bp_third", hs_a.out_payload, 32'hA2);
    chk("bp_third_valid", {31'b0, hs_a.out_valid}, 32'd1);
    hs_a.in_valid = 1'b0;
    tick();
    chk("bp_empty", {31'b0, hs_a.out_valid}, 32'd0);
    chk("bp_cnt_final", {16'b0, cnt_a}, 32'd3);

    // flush with a full skid and 0xDEAD on the input
    hs_a.out_ready  = 1'b0;
    hs_a.in_valid   = 1'b1;
    hs_a.in_payload = 32'hB0;
    tick();
    hs_a.in_payload = 32'hB1;
    tick();
    chk("fl_occ_full", {30'b0, occ_a}, 32'd2);
    hs_a.in_payload = 32'hDEAD;
    flush_a = 1'b1;
    tick();
    chk("fl_out_valid", {31'b0, hs_a.out_valid}, 32'd0);
    chk("fl_occ", {30'b0, occ_a}, 32'd0);
    chk("fl_in_ready", {31'b0, hs_a.in_ready}, 32'd1);
    tick();
    chk("fl_discard_ready1", {31'b0, hs_a.out_valid}, 32'd0);
    flush_a = 1'b0;
    hs_a.in_valid  = 1'b0;
    hs_a.out_ready = 1'b1;
    tick();
    chk("fl_no_dead", {31'b0, hs_a.out_valid}, 32'd0);
    chk("fl_cnt_kept", {16'b0, cnt_a}, 32'd5);

    // single-entry mode: combinational in_ready
    hs_b.in_valid   = 1'b1;
    hs_b.in_payload = 32'h11;
    tick();
    chk("s0_full", hs_b.out_payload, 32'h11);
    chk("s0_in_ready0", {31'b0, hs_b.in_ready}, 32'd0);
    hs_b.out_ready  = 1'b1;
    hs_b.in_payload = 32'h22;
    #1;
    chk("s0_in_ready_comb", {31'b0, hs_b.in_ready}, 32'd1);
    tick();
    chk("s0_pass_valid", {31'b0, hs_b.out_valid}, 32'd1);
    chk("s0_pass_payload", hs_b.out_payload, 32'h22);
    chk("s0_occ", {30'b0, occ_b}, 32'd1);
    hs_b.in_valid = 1'b0;
    tick();
    chk("s0_drain", {31'b0, hs_b.out_valid}, 32'd0);

    // saturation on the 4-bit counter
    hs_c.in_valid   = 1'b1;
    hs_c.in_payload = 32'h55;
    tick();
    hs_c.in_valid = 1'b0;
    repeat (14) tick();
    chk("sat_14", {28'b0, cnt_c}, 32'd14);
    repeat (6) tick();
    chk("sat_15", {28'b0, cnt_c}, 32'd15);
    clr_c = 1'b1;
    tick();
    chk("sat_clr", {28'b0, cnt_c}, 32'd0);
    clr_c = 1'b0;
    tick();
    chk("sat_after_clr", {28'b0, cnt_c}, 32'd1);

    // asynchronous reset between edges with both skid entries full
    hs_a.in_valid   = 1'b1;
    hs_a.in_payload = 32'hC1;
    tick();
    hs_a.in_payload = 32'hC2;
    tick();
    hs_a.out_ready  = 1'b0;
    hs_a.in_payload = 32'hC3;
    tick();
    chk("ar_pre_occ", {30'b0, occ_a}, 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", {31'b0, hs_a.out_valid}, 32'd0);
    chk("ar_occ", {30'b0, occ_a}, 32'd0);
    chk("ar_cnt_a", {16'b0, cnt_a}, 32'd0);
    chk("ar_cnt_c", {28'b0, cnt_c}, 32'd0);
    chk("ar_in_ready", {31'b0, hs_a.in_ready}, 32'd1);
    #1;
    rst = 1'b0;
    hs_a.in_payload = 32'hE1;
    hs_a.out_ready  = 1'b1;
    tick();
    chk("ar_first_valid", {31'b0, hs_a.out_valid}, 32'd1);
    chk("ar_first_payload", hs_a.out_payload, 32'hE1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_stage_hs_reg.md
# ex_stage_hs_reg

Parametrised successor to the fixed-field EX pipeline register. It carries one packed stage payload from decode to execute under a valid/ready handshake, with synchronous flush and an optional two-entry skid buffer that cuts the combinational ready path. A saturating stall counter supports performance analysis. It sits between ID and EX and replaces the per-field always-enabled flops with a stallable, flushable stage.

## Interface
Parameters:
- PAYLOAD_W, 256: packed payload width (pc, instr, imm, rs1, rs2, aluctr, jump/branch flags, src selects, concatenated by the instantiating stage).
- SKID, 1: 1 gives a two-entry skid buffer with registered in_ready; 0 gives a single entry with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept the payload this cycle.
- in_payload  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  EX-side payload is valid.
- out_ready  in  1  EX consumes the payload this cycle.
- out_payload  out  PAYLOAD_W  payload presented to EX.
- flush  in  1  synchronous kill of all held and incoming payloads (branch or jump redirect).
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Accept: in_valid & in_ready. Emit: out_valid & out_ready.
- Storage: main entry (m_valid, m_data) drives out_valid and out_payload. Skid entry (s_valid, s_data) exists only when SKID=1.
- SKID=0:
  - in_ready = ~m_valid | out_ready.
  - On accept, m_data <= in_payload and m_valid <= 1.
  - On emit without accept, m_valid <= 0.
- SKID=1:
  - in_ready = ~s_valid, purely from a register.
  - Accept with main empty, or with main emitting and skid empty: data goes to main.
  - Accept with main full and not emitting: data goes to skid.
  - Emit with skid full: main <= skid and skid empties. A same-cycle accept is impossible because in_ready=0.
  - FIFO order is always preserved.
- Flush:
  - Has highest priority. Next cycle m_valid=0 and s_valid=0.
  - An input presented in the flush cycle is discarded even if in_ready=1.
  - Data registers hold their old values; their contents are don't-care while the valid bit is 0.
- occupancy = m_valid + s_valid.
- stall_cnt:
  - Increments when out_valid & ~out_ready and it is below 2^CNT_W-1; it holds at the maximum.
  - stall_cnt_clr has priority over the increment.
  - Flush does not clear the counter.
- out_payload is the registered m_data with no combinational path from in_payload.

## Timing
- Reset values: out_valid=0, occupancy=0, stall_cnt=0, out_payload=0, skid data=0, in_ready=1 (both modes).
- Reset asserted mid-transfer drops every entry immediately and asynchronously.
- Latency: a payload accepted at edge N appears on out_valid/out_payload after edge N (one cycle) when main is empty or emitting.
- Throughput: one payload per cycle while out_ready=1, in both modes.
- SKID=1 back-pressure: out_ready falls at cycle N, then in_ready falls after the edge where skid fills (at most one extra payload absorbed). in_ready rises one cycle after the skid drains.
- Simultaneous flush and out_ready: the emit at that edge is still a valid transfer (EX sees it); only the state after the edge is empty.
- Simultaneous stall_cnt_clr and stall condition: counter = 0.

## Test plan
- Stream (SKID=1): in_valid=1 with payloads 0x1..0x8, out_ready=1 throughout -> out_payload 0x1..0x8 on consecutive cycles, one cycle after each accept; occupancy never exceeds 1.
- Back-pressure: stream 0xA0.. and drop out_ready for 3 cycles -> exactly one extra payload enters skid, occupancy=2, in_ready=0. On release, order is 0xA0, 0xA1, 0xA2 with no loss or duplicate; stall_cnt=3.
- Flush with a full skid plus in_valid=1 carrying 0xDEAD -> next cycle out_valid=0 and occupancy=0, 0xDEAD never emitted; in_ready=1 the following cycle.
- SKID=0: out_ready=0 with main full -> in_ready=0 in the same cycle. Raise out_ready with in_valid=1 -> accept and emit in the same cycle, out_valid stays 1.
- Saturation (CNT_W=4): hold the stall condition for 20 cycles -> stall_cnt=15. Pulse stall_cnt_clr while stalled -> stall_cnt=0 and increments the next cycle.
- Asynchronous rst raised mid-stream between clock edges -> out_valid=0, occupancy=0, stall_cnt=0 immediately. After release, the first accepted payload appears after one edge.
